m_proc_multicycle: RTL and testbench
====================================

M_PROC_MULTICYCLE -- requirements
Module: m_proc_multicycle

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath and register width.
REQ-002 SHALL have parameter NREG, default 32, register count; index width AW = clog2(NREG).
REQ-003 SHALL have parameter RESET_PC, default 0, PC value after reset.
REQ-004 SHALL have port w_clock, input, 1 bit: single clock, all state updates on posedge.
REQ-005 SHALL have port w_rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port w_imem_req, output, 1 bit: fetch request.
REQ-007 SHALL have port w_imem_addr, output, XLEN bits: fetch byte address, equal to the current PC.
REQ-008 SHALL have port w_imem_ack, input, 1 bit: fetch data valid this cycle.
REQ-009 SHALL have port w_imem_data, input, 32 bits: instruction word.
REQ-010 SHALL have port w_pc, output, XLEN bits: current PC.
REQ-011 SHALL have port w_halt, output, 1 bit: sticky halt flag.
REQ-012 SHALL have port w_dbg_ra, input, AW bits: debug register index.
REQ-013 SHALL have port w_dbg_rd, output, XLEN bits: combinational read of register w_dbg_ra.

Function
REQ-014 SHALL use FSM states IF, ID, EX, WB, HALT.
REQ-015 IF: w_imem_req=1; on w_imem_ack=1, latch w_imem_data into IR and go to ID; otherwise stay in IF with address held stable.
REQ-016 ID: latch rs1/rs2 register values and the sign-extended immediate; go to EX.
REQ-017 EX: compute the ALU result and branch decision; an illegal instruction goes to HALT, otherwise to WB.
REQ-018 WB: write rd when rd!=0 for ADD/SUB/ADDI; PC <= branch target or PC+4 (mod 2^XLEN); go to IF.
REQ-019 Latency: an instruction takes exactly 4 cycles when ack arrives in the first IF cycle, plus 1 cycle per IF wait cycle.
REQ-020 Supported instructions: ADD (opcode 0110011, f3 000, f7 0000000), SUB (f7 0100000), and ADDI (opcode 0010011, f3 000).
REQ-021 Arithmetic SHALL be XLEN-bit with wrap-around and no overflow trap; the 12-bit immediate SHALL be sign-extended to XLEN.
REQ-022 Register x0 SHALL read 0 always; writes to x0 SHALL be discarded.
REQ-023 Any other encoding SHALL be illegal -> HALT.
REQ-024 In HALT: w_halt=1, w_imem_req=0, PC frozen, no register writes; HALT SHALL be exited only by reset.
REQ-025 w_imem_ack outside IF SHALL be ignored.

Reset
REQ-026 When w_rst_n=0 at a posedge: state<=IF, PC<=RESET_PC, all registers<=0, IR<=0, w_halt<=0.
REQ-027 Reset SHALL take priority in every state, including mid-fetch and HALT; the first request appears in the cycle after reset is released.

Configuration
REQ-028 With PROC_BRANCH_EN defined, BNE (opcode 1100011, f3 001) SHALL be supported: if rs1!=rs2, PC <= PC + sign-extended B-immediate; no register write.
REQ-029 Without PROC_BRANCH_EN, BNE SHALL be illegal -> HALT.

Structure
REQ-030 Opcode/funct constants and the FSM state typedef SHALL live in the shared package proc_pkg.
REQ-031 The register file SHALL be sub-module m_regfile: NREG x XLEN, two async read ports, a debug read port, one sync write port, and x0 hardwired to zero.

Verification
REQ-032 Reset, then ADDI x1,x0,3 (0x00300093) with immediate ack -> x1=3 after 4 cycles; w_pc=4.
REQ-033 Then ADD x2,x1,x1 (0x00108133), then SUB x3,x2,x1 (0x401101B3) -> x2=6, x3=3; w_pc=12.
REQ-034 Ack delayed by 3 cycles -> IF held 4 cycles with w_imem_addr stable; the instruction completes in 7 cycles.
REQ-035 Illegal word 0xFFFFFFFF -> w_halt=1 from the cycle after EX; no further w_imem_req; w_halt clears only after w_rst_n=0.
REQ-036 With PROC_BRANCH_EN: x1=3, BNE x1,x0,-4 (0xFE009EE3) at PC 8 -> next w_imem_addr=4. Without PROC_BRANCH_EN, the same word -> HALT.
REQ-037 ADDI x0,x0,5 -> w_dbg_rd for index 0 reads 0; ADDI x1,x1,-1 with x1=0 -> x1=0xFFFFFFFF.

Source files
------------

// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : proc_pkg
//  Description : Shared definitions for the multicycle processor: FSM state
//                encoding and the opcode/funct field constants it decodes.
//  Revision    : 1.0 - initial release
// ============================================================================
package proc_pkg;

  // Explicit 3-bit encoding; the unused codes fall back to IF in the FSM.
  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_WB   = 3'd3,
    S_HALT = 3'd4
  } state_t;

  localparam logic [6:0] c_OPC_OP     = 7'b0110011;
  localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] c_F3_ADD_SUB = 3'b000;
  localparam logic [2:0] c_F3_BNE     = 3'b001;

  localparam logic [6:0] c_F7_ADD     = 7'b0000000;
  localparam logic [6:0] c_F7_SUB     = 7'b0100000;

endpackage
`default_nettype wire

// File: rtl/m_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : m_regfile
//  Description : NREG x XLEN register file. Two asynchronous read ports, one
//                asynchronous debug read port, one synchronous write port.
//                Register x0 always reads zero and ignores writes.
//  Ports       : w_clock, w_rst_n (sync, active-low, clears all registers)
//                w_ra1/w_rd1, w_ra2/w_rd2 : operand read ports
//                w_dbg_ra/w_dbg_rd        : debug read port
//                w_we, w_wa, w_wd         : write port
//  Revision    : 1.0 - initial release
// ============================================================================
module m_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic                    w_clock,
  input  logic                    w_rst_n,
  input  logic [$clog2(NREG)-1:0] w_ra1,
  output logic [XLEN-1:0]         w_rd1,
  input  logic [$clog2(NREG)-1:0] w_ra2,
  output logic [XLEN-1:0]         w_rd2,
  input  logic [$clog2(NREG)-1:0] w_dbg_ra,
  output logic [XLEN-1:0]         w_dbg_rd,
  input  logic                    w_we,
  input  logic [$clog2(NREG)-1:0] w_wa,
  input  logic [XLEN-1:0]         w_wd
);

  logic [XLEN-1:0] r_regs [NREG];

  always_ff @(posedge w_clock) begin
    if (!w_rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_we && (w_wa != '0)) begin
      r_regs[w_wa] <= w_wd;
    end
  end

  // x0 is forced to zero at the read mux so it never depends on storage.
  assign w_rd1    = (w_ra1    == '0) ? '0 : r_regs[w_ra1];
  assign w_rd2    = (w_ra2    == '0) ? '0 : r_regs[w_ra2];
  assign w_dbg_rd = (w_dbg_ra == '0) ? '0 : r_regs[w_dbg_ra];

endmodule
`default_nettype wire

// File: rtl/m_proc_multicycle.sv
`default_nettype none
// ============================================================================
//  Module      : m_proc_multicycle
//  Description : Multicycle (IF/ID/EX/WB) processor executing ADD, SUB and
//                ADDI; any other encoding halts until reset. Defining the
//                macro PROC_BRANCH_EN adds BNE support.
//  Ports       : w_clock, w_rst_n (sync, active-low)
//                w_imem_req/w_imem_addr/w_imem_ack/w_imem_data : fetch bus
//                w_pc   : current PC      w_halt : sticky halt flag
//                w_dbg_ra/w_dbg_rd : combinational register debug read
//  Revision    : 1.0 - initial release
// ============================================================================
module m_proc_multicycle
  import proc_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              NREG     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                    w_clock,
  input  logic                    w_rst_n,
  output logic                    w_imem_req,
  output logic [XLEN-1:0]         w_imem_addr,
  input  logic                    w_imem_ack,
  input  logic [31:0]             w_imem_data,
  output logic [XLEN-1:0]         w_pc,
  output logic                    w_halt,
  input  logic [$clog2(NREG)-1:0] w_dbg_ra,
  output logic [XLEN-1:0]         w_dbg_rd
);

  localparam int              AW         = $clog2(NREG);
  localparam logic [XLEN-1:0] c_PC_STEP  = XLEN'(4);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_pc, r_a, r_b, r_imm, r_result, r_next_pc;
  logic [31:0]     r_ir;

  // Instruction fields. Register indices use the low AW bits (NREG <= 32).
  logic [6:0]      w_opcode, w_f7;
  logic [2:0]      w_f3;
  logic [AW-1:0]   w_rd_idx, w_rs1_idx, w_rs2_idx;
  logic [XLEN-1:0] w_imm_i, w_imm_sel, w_rs1_val, w_rs2_val, w_alu;
  logic            w_is_add, w_is_sub, w_is_addi, w_legal, w_writes;
  logic            w_branch_taken, w_rf_we;

  assign w_opcode  = r_ir[6:0];
  assign w_f3      = r_ir[14:12];
  assign w_f7      = r_ir[31:25];
  assign w_rd_idx  = r_ir[7  +: AW];
  assign w_rs1_idx = r_ir[15 +: AW];
  assign w_rs2_idx = r_ir[20 +: AW];
  assign w_imm_i   = {{(XLEN-12){r_ir[31]}}, r_ir[31:20]};

  assign w_is_add  = (w_opcode == c_OPC_OP) && (w_f3 == c_F3_ADD_SUB) && (w_f7 == c_F7_ADD);
  assign w_is_sub  = (w_opcode == c_OPC_OP) && (w_f3 == c_F3_ADD_SUB) && (w_f7 == c_F7_SUB);
  assign w_is_addi = (w_opcode == c_OPC_OP_IMM) && (w_f3 == c_F3_ADD_SUB);
  assign w_writes  = w_is_add || w_is_sub || w_is_addi;

`ifdef PROC_BRANCH_EN
  logic            w_is_bne;
  logic [XLEN-1:0] w_imm_b;
  assign w_is_bne       = (w_opcode == c_OPC_BRANCH) && (w_f3 == c_F3_BNE);
  assign w_imm_b        = {{(XLEN-13){r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
  assign w_imm_sel      = w_is_bne ? w_imm_b : w_imm_i;
  assign w_legal        = w_writes || w_is_bne;
  assign w_branch_taken = w_is_bne && (r_a != r_b);
`else
  assign w_imm_sel      = w_imm_i;
  assign w_legal        = w_writes;
  assign w_branch_taken = 1'b0;
`endif

  // SUB uses rs2; ADD uses rs2; ADDI swaps in the latched immediate.
  assign w_alu = w_is_sub ? (r_a - r_b) : (r_a + (w_is_addi ? r_imm : r_b));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge w_clock) begin
    if (!w_rst_n) begin
      r_state <= S_IF;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IF:    w_state_nxt = w_imem_ack ? S_ID : S_IF;
      S_ID:    w_state_nxt = S_EX;
      S_EX:    w_state_nxt = w_legal ? S_WB : S_HALT;
      S_WB:    w_state_nxt = S_IF;
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_IF;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    w_imem_req = 1'b0;
    w_halt     = 1'b0;
    w_rf_we    = 1'b0;
    case (r_state)
      S_IF:    w_imem_req = 1'b1;
      S_WB:    w_rf_we    = w_writes;
      S_HALT:  w_halt     = 1'b1;
      default: ;
    endcase
  end

  // ---------------- Datapath ----------------
  always_ff @(posedge w_clock) begin
    if (!w_rst_n) begin
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_imm     <= '0;
      r_result  <= '0;
      r_next_pc <= RESET_PC;
    end else begin
      case (r_state)
        S_IF: if (w_imem_ack) r_ir <= w_imem_data;
        S_ID: begin
          r_a   <= w_rs1_val;
          r_b   <= w_rs2_val;
          r_imm <= w_imm_sel;
        end
        S_EX: begin
          r_result  <= w_alu;
          r_next_pc <= w_branch_taken ? (r_pc + r_imm) : (r_pc + c_PC_STEP);
        end
        S_WB:    r_pc <= r_next_pc;
        default: ;
      endcase
    end
  end

  assign w_imem_addr = r_pc;
  assign w_pc        = r_pc;

  m_regfile #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_regfile (
    .w_clock  (w_clock),
    .w_rst_n  (w_rst_n),
    .w_ra1    (w_rs1_idx),
    .w_rd1    (w_rs1_val),
    .w_ra2    (w_rs2_idx),
    .w_rd2    (w_rs2_val),
    .w_dbg_ra (w_dbg_ra),
    .w_dbg_rd (w_dbg_rd),
    .w_we     (w_rf_we),
    .w_wa     (w_rd_idx),
    .w_wd     (r_result)
  );

endmodule
`default_nettype wire

// File: tb/tb_m_proc_multicycle.sv
`default_nettype none
// ============================================================================
//  Module      : tb_m_proc_multicycle
//  Description : Self-checking bench for m_proc_multicycle. Directed vectors
//                followed by random ADD/SUB/ADDI (and BNE when PROC_BRANCH_EN
//                is defined) against an architectural model of registers/PC.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_m_proc_multicycle;

  logic        w_clock = 1'b0;
  logic        w_rst_n;
  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic        w_imem_ack;
  logic [31:0] w_imem_data;
  logic [31:0] w_pc;
  logic        w_halt;
  logic [4:0]  w_dbg_ra;
  logic [31:0] w_dbg_rd;

  always #5 w_clock = ~w_clock;

  m_proc_multicycle dut (
    .w_clock     (w_clock),
    .w_rst_n     (w_rst_n),
    .w_imem_req  (w_imem_req),
    .w_imem_addr (w_imem_addr),
    .w_imem_ack  (w_imem_ack),
    .w_imem_data (w_imem_data),
    .w_pc        (w_pc),
    .w_halt      (w_halt),
    .w_dbg_ra    (w_dbg_ra),
    .w_dbg_rd    (w_dbg_rd)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge w_clock) cyc <= cyc + 1;

  // Architectural model
  logic [31:0] m_reg [32];
  logic [31:0] m_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1, input int rd);
    return {f7, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int rd);
    return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_bne(input int imm, input int rs1, input int rs2);
    logic [12:0] b;
    b = 13'(imm);
    return {b[12], b[10:5], 5'(rs2), 5'(rs1), 3'b001, b[4:1], b[11], 7'b1100011};
  endfunction

  task automatic check_reg(input int r);
    w_dbg_ra = 5'(r);
    #1;
    check($sformatf("x%0d", r), w_dbg_rd, m_reg[r]);
  endtask

  task automatic check_all_regs();
    for (int r = 0; r < 32; r++) check_reg(r);
  endtask

  // Holds reset for a few cycles, checks reset state, releases reset and
  // leaves the bench at a negedge with the DUT in its first fetch cycle.
  task automatic reset_dut();
    w_rst_n    = 1'b0;
    w_imem_ack = 1'b1;              // ack during reset must not matter
    w_imem_data = 32'h00100093;
    for (int r = 0; r < 32; r++) m_reg[r] = '0;
    m_pc = 32'h0;
    repeat (2) @(negedge w_clock);
    w_imem_ack = 1'b0;
    @(negedge w_clock);
    check("rst_pc", w_pc, m_pc);
    check("rst_halt", {31'b0, w_halt}, 32'h0);
    check_all_regs();
    @(negedge w_clock);
    w_rst_n = 1'b1;
    @(negedge w_clock);
    check("rst_req", {31'b0, w_imem_req}, 32'h1);
    check("rst_addr", w_imem_addr, m_pc);
  endtask

  // Runs one instruction from a fetch cycle. Ack pulses with junk data are
  // driven during ID/EX/WB to confirm they are ignored.
  task automatic exec(input logic [31:0] word, input int delay, input bit expect_halt);
    int start;
    start = cyc;
    check("if_req", {31'b0, w_imem_req}, 32'h1);
    check("if_addr", w_imem_addr, m_pc);
    for (int i = 0; i < delay; i++) begin
      w_imem_ack  = 1'b0;
      w_imem_data = $urandom;
      @(negedge w_clock);
      check("wait_req", {31'b0, w_imem_req}, 32'h1);
      check("wait_addr", w_imem_addr, m_pc);
    end
    w_imem_ack  = 1'b1;
    w_imem_data = word;
    @(negedge w_clock);
    check("id_req", {31'b0, w_imem_req}, 32'h0);
    w_imem_ack  = 1'b1;
    w_imem_data = $urandom;
    @(negedge w_clock);
    check("ex_req", {31'b0, w_imem_req}, 32'h0);
    check("ex_halt", {31'b0, w_halt}, 32'h0);
    w_imem_ack  = 1'($urandom_range(0, 1));
    w_imem_data = $urandom;
    @(negedge w_clock);
    check("post_ex_halt", {31'b0, w_halt}, {31'b0, expect_halt});
    check("post_ex_req", {31'b0, w_imem_req}, 32'h0);
    w_imem_ack = 1'b0;
    if (!expect_halt) begin
      @(negedge w_clock);
      check("latency", 32'(cyc - start), 32'(delay + 4));
    end
  endtask

  // Executes a legal instruction, updates the model with the architectural
  // result and checks PC and the destination register afterwards.
  task automatic step(input logic [31:0] word, input int delay, input int rd,
                      input logic [31:0] new_val, input logic [31:0] next_pc);
    exec(word, delay, 1'b0);
    if (rd != 0) m_reg[rd] = new_val;
    m_pc = next_pc;
    check("pc", w_pc, m_pc);
    check_reg(rd);
  endtask

  // Checks the DUT stays frozen in HALT while fetch acks keep arriving.
  task automatic check_halted(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      w_imem_ack  = 1'b1;
      w_imem_data = 32'h00500093;
      @(negedge w_clock);
      check("halt_flag", {31'b0, w_halt}, 32'h1);
      check("halt_req", {31'b0, w_imem_req}, 32'h0);
      check("halt_pc", w_pc, m_pc);
    end
    w_imem_ack = 1'b0;
  endtask

  initial begin
    w_rst_n     = 1'b0;
    w_imem_ack  = 1'b0;
    w_imem_data = '0;
    w_dbg_ra    = '0;

    // ---- directed vectors ----
    reset_dut();
    step(32'h00300093, 0, 1, m_reg[0] + 32'd3, m_pc + 4);        // ADDI x1,x0,3
    step(32'h00108133, 0, 2, m_reg[1] + m_reg[1], m_pc + 4);     // ADD x2,x1,x1
    step(32'h401101B3, 0, 3, m_reg[2] - m_reg[1], m_pc + 4);     // SUB x3,x2,x1
    check("pc_after_3", w_pc, 32'd12);
    step(32'hFF900213, 3, 4, m_reg[0] - 32'd7, m_pc + 4);        // ADDI x4,x0,-7, late ack
    step(32'h00500013, 1, 0, 32'h0, m_pc + 4);                   // ADDI x0,x0,5
    step(32'hFFF28293, 0, 5, m_reg[5] - 32'd1, m_pc + 4);        // ADDI x5,x5,-1
    check("x5_wrap", m_reg[5], 32'hFFFFFFFF);

    // ---- reset in the middle of a stalled fetch ----
    w_imem_ack = 1'b0;
    repeat (2) @(negedge w_clock);
    reset_dut();

    // ---- BNE at PC 8 ----
    step(32'h00300093, 0, 1, 32'd3, m_pc + 4);
    step(32'h00000013, 0, 0, 32'd0, m_pc + 4);
`ifdef PROC_BRANCH_EN
    step(32'hFE009EE3, 0, 0, 32'd0, m_pc - 4);
    check("bne_target", w_imem_addr, 32'd4);
    step(enc_bne(-8, 0, 0), 0, 0, 32'd0, m_pc + 4);              // not taken
`else
    exec(32'hFE009EE3, 0, 1'b1);
    check_halted(3);
`endif

    // ---- random instruction stream ----
    reset_dut();
    for (int n = 0; n < 80; n++) begin
      int kind, rd, rs1, rs2, imm, dly;
      kind = $urandom_range(0, 3);
      rd   = $urandom_range(0, 31);
      rs1  = $urandom_range(0, 31);
      rs2  = $urandom_range(0, 31);
      imm  = int'($urandom_range(0, 4095)) - 2048;
      dly  = $urandom_range(0, 3);
      case (kind)
        0: step(enc_r(7'h00, rs2, rs1, rd), dly, rd, m_reg[rs1] + m_reg[rs2], m_pc + 4);
        1: step(enc_r(7'h20, rs2, rs1, rd), dly, rd, m_reg[rs1] - m_reg[rs2], m_pc + 4);
`ifdef PROC_BRANCH_EN
        3: step(enc_bne(imm * 2, rs1, rs2), dly, 0, 32'd0,
                (m_reg[rs1] != m_reg[rs2]) ? m_pc + 32'(imm * 2) : m_pc + 4);
`endif
        default: step(enc_i(imm, rs1, rd), dly, rd, m_reg[rs1] + 32'(imm), m_pc + 4);
      endcase
    end

    // ---- illegal instruction, sticky halt, reset recovery ----
    exec(32'hFFFFFFFF, 1, 1'b1);
    check_halted(4);
    check_all_regs();
    @(negedge w_clock);
    check("halt_held", {31'b0, w_halt}, 32'h1);
    w_rst_n = 1'b0;
    @(negedge w_clock);
    check("halt_cleared", {31'b0, w_halt}, 32'h0);
    reset_dut();
    step(enc_i(-1, 0, 7), 0, 7, 32'hFFFFFFFF, m_pc + 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
